// File: rtl/booth_mult_unit_pkg.sv
// booth_mult_unit_pkg
//   Shared definitions for the Booth multiplier slice: FSM state encodings
//   (also decoded by the pipeline controller for stall generation), the
//   default operand width, and the radix-2 Booth recoding helper.
package booth_mult_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the {Q[0], q_m1} bit pair.
  function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b01:   return OP_ADD;
      2'b10:   return OP_SUB;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_mult_unit_if.sv
// booth_mult_unit_if
//   Request/result bundle between the execute-stage controller (master) and
//   the multiplier (slave).
//   Signals: start, a, b (request); busy, done, product_hi, product_lo
//   (status/result); state (debug view of the multiplier FSM).
//
// Handshake: start is sampled on a rising edge only while the multiplier is
// in IDLE or DONE; a and b are captured on that same edge. busy is high for
// exactly WIDTH cycles while iterating and start is ignored then. done is a
// one-cycle pulse marking product_hi/product_lo valid; the products then hold
// until the next completion. Asserting start during the done cycle issues the
// next multiply back to back.
interface booth_mult_unit_if import booth_mult_unit_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;
  state_t           state;

  modport master (
    output start, a, b,
    input  busy, done, product_hi, product_lo, state
  );

  modport slave (
    input  start, a, b,
    output busy, done, product_hi, product_lo, state
  );

endinterface

// File: rtl/booth_mult_unit_booth_step.sv
// booth_step
//   One combinational radix-2 Booth iteration: add M, subtract M or keep ACC
//   according to {Q[0], q_m1}, then arithmetic right shift of {ACC', Q, q_m1}.
//   Inputs : acc (WIDTH+1), q (WIDTH), q_m1, m (WIDTH+1, sign-extended a)
//   Outputs: acc_next, q_next, q_m1_next
module booth_step import booth_mult_unit_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] sum;

  // ACC carries one extra bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    sum = acc;
    case (booth_decode(q[0], q_m1))
      OP_ADD:  sum = acc + m;
      OP_SUB:  sum = acc - m;
      default: sum = acc;
    endcase
  end

  assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_next = q[0];

endmodule

// File: rtl/booth_mult_unit.sv
// booth_mult_unit
//   Sequential signed WIDTH x WIDTH multiplier, radix-2 Booth, one iteration
//   per cycle, 2*WIDTH-bit product.
//   Ports: clk, rst (synchronous, active-low), bus (booth_mult_unit_if.slave:
//   start/a/b in; busy/done/product_hi/product_lo/state out).
//   busy and done are decoded straight from the state register, so nothing
//   combinational runs from the request inputs to any output.
module booth_mult_unit import booth_mult_unit_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  booth_mult_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   m;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH-1:0] product_hi;
  logic [WIDTH-1:0] product_lo;

  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] q_n;
  logic             q_m1_n;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .q         (q),
    .q_m1      (q_m1),
    .m         (m),
    .acc_next  (acc_n),
    .q_next    (q_n),
    .q_m1_next (q_m1_n)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= '0;
      acc        <= '0;
      m          <= '0;
      q          <= '0;
      q_m1       <= 1'b0;
      product_hi <= '0;
      product_lo <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            m     <= {bus.a[WIDTH-1], bus.a};
            acc   <= '0;
            q     <= bus.b;
            q_m1  <= 1'b0;
            count <= CW'(WIDTH);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_n;
          q     <= q_n;
          q_m1  <= q_m1_n;
          count <= count - CW'(1);
          // Last iteration: the product is the shifted pair, captured only here
          // so the outputs never show a partial result.
          if (count == CW'(1)) begin
            product_hi <= acc_n[WIDTH-1:0];
            product_lo <= q_n;
            state      <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.product_hi = product_hi;
  assign bus.product_lo = product_lo;
  assign bus.state      = state;

endmodule

// File: tb/tb_booth_mult_unit.sv
// tb_booth_mult_unit
//   Directed bench for booth_mult_unit: reset, signed products including the
//   extreme operands, back-to-back issue with held start, and reset mid-run.
module tb_booth_mult_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  booth_mult_unit_if #(.WIDTH(W)) bus ();

  booth_mult_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one multiply from IDLE and check latency, done pulse and product.
  task automatic run_mult(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int busy_cycles;
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    busy_cycles = 0;
    while (bus.busy && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'(W));
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_hi"}, 64'(bus.product_hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.product_lo), 64'(exp_lo));
    tick();
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    int  n;
    bit  done_seen;
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    // reset then idle
    tick();
    tick();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.product_hi), 64'd0);
    check("rst_lo", 64'(bus.product_lo), 64'd0);
    rst = 1'b1;
    tick();
    check("idle_busy", 64'(bus.busy), 64'd0);

    // directed products
    run_mult("pos_7x6", 32'd7, 32'd6, 32'h0000_0000, 32'd42);
    run_mult("neg3x5", 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_mult("min_x_min", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_mult("min_x_max", 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 32'h8000_0000);

    // start held high; a changes mid-run and is picked up only in DONE
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    tick();
    n = 0;
    while (!bus.done && n < 100) begin
      tick();
      n++;
      if (n == 10) bus.a = 32'd9;
    end
    check("hs_first_latency", 64'(n), 64'(W));
    check("hs_first_hi", 64'(bus.product_hi), 64'd0);
    check("hs_first_lo", 64'(bus.product_lo), 64'd6);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done && n < 100);
    check("hs_done_spacing", 64'(n), 64'(W + 1));
    check("hs_second_hi", 64'(bus.product_hi), 64'd0);
    check("hs_second_lo", 64'(bus.product_lo), 64'd27);
    bus.start = 1'b0;
    tick();
    check("hs_back_idle_busy", 64'(bus.busy), 64'd0);
    check("hs_back_idle_done", 64'(bus.done), 64'd0);

    // reset at iteration 10 of 100*100
    bus.a     = 32'd100;
    bus.b     = 32'd100;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("mid_busy_before_rst", 64'(bus.busy), 64'd1);
    rst = 1'b0;
    tick();
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_hi", 64'(bus.product_hi), 64'd0);
    check("mid_rst_lo", 64'(bus.product_lo), 64'd0);
    rst = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) done_seen = 1'b1;
    end
    check("mid_no_done", 64'(done_seen), 64'd0);
    check("mid_hold_lo", 64'(bus.product_lo), 64'd0);
    run_mult("after_rst_100x100", 32'd100, 32'd100, 32'h0000_0000, 32'd10000);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
